// File: rtl/ycbcr2rgb_pipe.sv
// ycbcr2rgb_pipe: three-stage YCbCr -> RGB converter, PPC pixels per beat.
//   S1 removes the luma/chroma offsets, S2 forms the five coefficient
//   products, S3 sums, rounds, clamps and holds the output beat.
//   Each beat carries its own mode (matrix + range), so mode changes need no flush.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   i_mode[1:0]          bit0 0=BT.601 1=BT.709; bit1 0=limited 1=full range
//   i_valid / o_ready    input handshake
//   i_y, i_cb, i_cr      PPC packed components, pixel p at [p*IN_WIDTH +: IN_WIDTH]
//   o_valid / i_ready    output handshake
//   o_r, o_g, o_b        PPC packed components, pixel p at [p*OUT_WIDTH +: OUT_WIDTH]
//   o_clip[PPC-1:0]      per pixel: some component was saturated
module ycbcr2rgb_pipe #(
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned OUT_WIDTH = 8,
    parameter int unsigned COEF_FRAC = 14,
    parameter int unsigned PPC       = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               i_mode,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [PPC*IN_WIDTH-1:0]  i_y,
    input  logic [PPC*IN_WIDTH-1:0]  i_cb,
    input  logic [PPC*IN_WIDTH-1:0]  i_cr,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [PPC*OUT_WIDTH-1:0] o_r,
    output logic [PPC*OUT_WIDTH-1:0] o_g,
    output logic [PPC*OUT_WIDTH-1:0] o_b,
    output logic [PPC-1:0]           o_clip
);

    localparam int unsigned DW = IN_WIDTH + 1;   // signed offset-removed component
    localparam int unsigned CW = COEF_FRAC + 3;  // coefficients < 4.0, plus a sign bit
    localparam int unsigned PW = DW + CW;        // product
    localparam int unsigned SW = PW + 2;         // sum of up to three products
    localparam int unsigned SH = COEF_FRAC + IN_WIDTH - OUT_WIDTH;

    localparam real SCALE = 2.0 ** COEF_FRAC;

    function automatic logic signed [CW-1:0] to_coef(input real v);
        return CW'($rtoi(v * SCALE + 0.5));
    endfunction

    localparam logic signed [CW-1:0] KY_LIM   = to_coef(1.164383);
    localparam logic signed [CW-1:0] KY_FULL  = to_coef(1.0);
    localparam logic signed [CW-1:0] RCR_601L = to_coef(1.596027);
    localparam logic signed [CW-1:0] GCB_601L = to_coef(0.391762);
    localparam logic signed [CW-1:0] GCR_601L = to_coef(0.812968);
    localparam logic signed [CW-1:0] BCB_601L = to_coef(2.017232);
    localparam logic signed [CW-1:0] RCR_709L = to_coef(1.792741);
    localparam logic signed [CW-1:0] GCB_709L = to_coef(0.213249);
    localparam logic signed [CW-1:0] GCR_709L = to_coef(0.532909);
    localparam logic signed [CW-1:0] BCB_709L = to_coef(2.112402);
    localparam logic signed [CW-1:0] RCR_601F = to_coef(1.402);
    localparam logic signed [CW-1:0] GCB_601F = to_coef(0.344136);
    localparam logic signed [CW-1:0] GCR_601F = to_coef(0.714136);
    localparam logic signed [CW-1:0] BCB_601F = to_coef(1.772);
    localparam logic signed [CW-1:0] RCR_709F = to_coef(1.5748);
    localparam logic signed [CW-1:0] GCB_709F = to_coef(0.187324);
    localparam logic signed [CW-1:0] GCR_709F = to_coef(0.468124);
    localparam logic signed [CW-1:0] BCB_709F = to_coef(1.8556);

    localparam logic [DW-1:0] YOFF = DW'(16) << (IN_WIDTH - 8);
    localparam logic [DW-1:0] COFF = DW'(1) << (IN_WIDTH - 1);

    localparam logic signed [SW-1:0] RND  = SW'(1) << (SH - 1);
    localparam logic signed [SW-1:0] MAXV = (SW'(1) << OUT_WIDTH) - SW'(1);

    // Returns {clipped, value}: round-shifted sum limited to [0, 2^OUT_WIDTH-1].
    function automatic logic [OUT_WIDTH:0] sat(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] q;
        q = s >>> SH;
        if (q[SW-1]) begin
            return {1'b1, {OUT_WIDTH{1'b0}}};
        end
        if (q > MAXV) begin
            return {1'b1, {OUT_WIDTH{1'b1}}};
        end
        return {1'b0, q[OUT_WIDTH-1:0]};
    endfunction

    // Handshake / ready chain: a stage loads when empty or when it drains forward.
    logic v1_q, v2_q, v3_q;
    logic en1, en2, en3;

    assign en3     = ~v3_q | i_ready;
    assign en2     = ~v2_q | en3;
    assign en1     = ~v1_q | en2;
    assign o_ready = en1;
    assign o_valid = v3_q;

    // S1: offset removal
    logic [1:0]    mode_q;
    logic [DW-1:0] yd_d  [PPC];
    logic [DW-1:0] cbd_d [PPC];
    logic [DW-1:0] crd_d [PPC];
    logic [DW-1:0] yd_q  [PPC];
    logic [DW-1:0] cbd_q [PPC];
    logic [DW-1:0] crd_q [PPC];

    always_comb begin
        for (int p = 0; p < PPC; p++) begin
            yd_d[p]  = {1'b0, i_y[p*IN_WIDTH +: IN_WIDTH]} - (i_mode[1] ? '0 : YOFF);
            cbd_d[p] = {1'b0, i_cb[p*IN_WIDTH +: IN_WIDTH]} - COFF;
            crd_d[p] = {1'b0, i_cr[p*IN_WIDTH +: IN_WIDTH]} - COFF;
        end
    end

    // S2: coefficient selection by the beat's own mode, then products
    logic signed [CW-1:0] ky, rcr, gcb, gcr, bcb;

    always_comb begin
        ky  = KY_LIM;
        rcr = RCR_601L;
        gcb = GCB_601L;
        gcr = GCR_601L;
        bcb = BCB_601L;
        unique case (mode_q)
            2'b00: begin
                ky = KY_LIM;  rcr = RCR_601L; gcb = GCB_601L; gcr = GCR_601L; bcb = BCB_601L;
            end
            2'b01: begin
                ky = KY_LIM;  rcr = RCR_709L; gcb = GCB_709L; gcr = GCR_709L; bcb = BCB_709L;
            end
            2'b10: begin
                ky = KY_FULL; rcr = RCR_601F; gcb = GCB_601F; gcr = GCR_601F; bcb = BCB_601F;
            end
            2'b11: begin
                ky = KY_FULL; rcr = RCR_709F; gcb = GCB_709F; gcr = GCR_709F; bcb = BCB_709F;
            end
        endcase
    end

    logic signed [PW-1:0] pky_d [PPC];
    logic signed [PW-1:0] prcr_d[PPC];
    logic signed [PW-1:0] pgcb_d[PPC];
    logic signed [PW-1:0] pgcr_d[PPC];
    logic signed [PW-1:0] pbcb_d[PPC];
    logic signed [PW-1:0] pky_q [PPC];
    logic signed [PW-1:0] prcr_q[PPC];
    logic signed [PW-1:0] pgcb_q[PPC];
    logic signed [PW-1:0] pgcr_q[PPC];
    logic signed [PW-1:0] pbcb_q[PPC];

    always_comb begin
        for (int p = 0; p < PPC; p++) begin
            pky_d[p]  = PW'($signed(yd_q[p]))  * PW'(ky);
            prcr_d[p] = PW'($signed(crd_q[p])) * PW'(rcr);
            pgcb_d[p] = PW'($signed(cbd_q[p])) * PW'(gcb);
            pgcr_d[p] = PW'($signed(crd_q[p])) * PW'(gcr);
            pbcb_d[p] = PW'($signed(cbd_q[p])) * PW'(bcb);
        end
    end

    // S3: sum, round, clamp
    logic [PPC*OUT_WIDTH-1:0] r_d, g_d, b_d, r_q, g_q, b_q;
    logic [PPC-1:0]           clip_d, clip_q;

    always_comb begin
        logic signed [SW-1:0] r_sum, g_sum, b_sum;
        logic [OUT_WIDTH:0]   r_s, g_s, b_s;
        r_d    = '0;
        g_d    = '0;
        b_d    = '0;
        clip_d = '0;
        for (int p = 0; p < PPC; p++) begin
            r_sum = SW'(pky_q[p]) + SW'(prcr_q[p]) + RND;
            g_sum = SW'(pky_q[p]) - SW'(pgcb_q[p]) - SW'(pgcr_q[p]) + RND;
            b_sum = SW'(pky_q[p]) + SW'(pbcb_q[p]) + RND;
            r_s   = sat(r_sum);
            g_s   = sat(g_sum);
            b_s   = sat(b_sum);
            r_d[p*OUT_WIDTH +: OUT_WIDTH] = r_s[OUT_WIDTH-1:0];
            g_d[p*OUT_WIDTH +: OUT_WIDTH] = g_s[OUT_WIDTH-1:0];
            b_d[p*OUT_WIDTH +: OUT_WIDTH] = b_s[OUT_WIDTH-1:0];
            clip_d[p] = r_s[OUT_WIDTH] | g_s[OUT_WIDTH] | b_s[OUT_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            v3_q   <= 1'b0;
            mode_q <= '0;
            yd_q   <= '{default: '0};
            cbd_q  <= '{default: '0};
            crd_q  <= '{default: '0};
            pky_q  <= '{default: '0};
            prcr_q <= '{default: '0};
            pgcb_q <= '{default: '0};
            pgcr_q <= '{default: '0};
            pbcb_q <= '{default: '0};
            r_q    <= '0;
            g_q    <= '0;
            b_q    <= '0;
            clip_q <= '0;
        end else begin
            if (en1) v1_q <= i_valid;
            if (en1 && i_valid) begin
                mode_q <= i_mode;
                yd_q   <= yd_d;
                cbd_q  <= cbd_d;
                crd_q  <= crd_d;
            end
            if (en2) v2_q <= v1_q;
            if (en2 && v1_q) begin
                pky_q  <= pky_d;
                prcr_q <= prcr_d;
                pgcb_q <= pgcb_d;
                pgcr_q <= pgcr_d;
                pbcb_q <= pbcb_d;
            end
            // Output register only changes on a real move, so it holds while stalled.
            if (en3) v3_q <= v2_q;
            if (en3 && v2_q) begin
                r_q    <= r_d;
                g_q    <= g_d;
                b_q    <= b_d;
                clip_q <= clip_d;
            end
        end
    end

    assign o_r    = r_q;
    assign o_g    = g_q;
    assign o_b    = b_q;
    assign o_clip = clip_q;

endmodule

// File: tb/tb_ycbcr2rgb_pipe.sv
// Self-checking bench for ycbcr2rgb_pipe (default parameters, PPC=2).
`timescale 1ns/1ps
module tb_ycbcr2rgb_pipe;

    localparam int IW   = 8;
    localparam int OW   = 8;
    localparam int CF   = 14;
    localparam int PPC  = 2;
    localparam int SH   = CF + IW - OW;
    localparam int MAXO = (1 << OW) - 1;
    localparam int NBEATS = 20;

    typedef struct packed {
        logic [PPC*OW-1:0] r;
        logic [PPC*OW-1:0] g;
        logic [PPC*OW-1:0] b;
        logic [PPC-1:0]    clip;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        i_mode;
    logic              i_valid;
    logic              o_ready;
    logic [PPC*IW-1:0] i_y, i_cb, i_cr;
    logic              o_valid;
    logic              i_ready;
    logic [PPC*OW-1:0] o_r, o_g, o_b;
    logic [PPC-1:0]    o_clip;

    ycbcr2rgb_pipe #(
        .IN_WIDTH (IW),
        .OUT_WIDTH(OW),
        .COEF_FRAC(CF),
        .PPC      (PPC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .i_mode (i_mode),
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_y    (i_y),
        .i_cb   (i_cb),
        .i_cr   (i_cr),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_r    (o_r),
        .o_g    (o_g),
        .o_b    (o_b),
        .o_clip (o_clip)
    );

    always #5 clk = ~clk;

    int    n_vec = 0;
    int    n_err = 0;
    beat_t exp_q[$];
    beat_t cur;

    assign cur = {o_r, o_g, o_b, o_clip};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int clampv(input longint v);
        if (v < 0) return 0;
        if (v > MAXO) return MAXO;
        return int'(v);
    endfunction

    // Reference: coefficients rounded from the real-valued matrix, plain integer maths.
    function automatic beat_t model_beat(input logic [PPC*IW-1:0] y, cb, cr,
                                         input logic [1:0] mode);
        beat_t  m;
        real    ky, krc, kgb, kgr, kbb;
        longint cy, crc, cgb, cgr, cbb, yd, cbd, crd, rs, gs, bs;
        case (mode)
            2'b00:   begin ky = 1.164383; krc = 1.596027; kgb = 0.391762; kgr = 0.812968; kbb = 2.017232; end
            2'b01:   begin ky = 1.164383; krc = 1.792741; kgb = 0.213249; kgr = 0.532909; kbb = 2.112402; end
            2'b10:   begin ky = 1.0;      krc = 1.402;    kgb = 0.344136; kgr = 0.714136; kbb = 1.772;    end
            default: begin ky = 1.0;      krc = 1.5748;   kgb = 0.187324; kgr = 0.468124; kbb = 1.8556;   end
        endcase
        cy  = $rtoi(ky  * (2.0 ** CF) + 0.5);
        crc = $rtoi(krc * (2.0 ** CF) + 0.5);
        cgb = $rtoi(kgb * (2.0 ** CF) + 0.5);
        cgr = $rtoi(kgr * (2.0 ** CF) + 0.5);
        cbb = $rtoi(kbb * (2.0 ** CF) + 0.5);
        m = '0;
        for (int p = 0; p < PPC; p++) begin
            yd  = longint'(y[p*IW +: IW])  - (mode[1] ? 0 : (16 << (IW - 8)));
            cbd = longint'(cb[p*IW +: IW]) - (1 << (IW - 1));
            crd = longint'(cr[p*IW +: IW]) - (1 << (IW - 1));
            rs  = (cy * yd + crc * crd + (longint'(1) << (SH - 1))) >>> SH;
            gs  = (cy * yd - cgb * cbd - cgr * crd + (longint'(1) << (SH - 1))) >>> SH;
            bs  = (cy * yd + cbb * cbd + (longint'(1) << (SH - 1))) >>> SH;
            m.r[p*OW +: OW] = OW'(clampv(rs));
            m.g[p*OW +: OW] = OW'(clampv(gs));
            m.b[p*OW +: OW] = OW'(clampv(bs));
            m.clip[p] = (rs < 0) || (rs > MAXO) || (gs < 0) || (gs > MAXO) ||
                        (bs < 0) || (bs > MAXO);
        end
        return m;
    endfunction

    function automatic beat_t mk(input int r, g, b, input logic c);
        beat_t m;
        m.r    = {PPC{OW'(r)}};
        m.g    = {PPC{OW'(g)}};
        m.b    = {PPC{OW'(b)}};
        m.clip = {PPC{c}};
        return m;
    endfunction

    // One beat on an idle pipe with i_ready=1; checks 3-cycle latency and data.
    task automatic directed(input string tag, input logic [1:0] mode,
                            input logic [PPC*IW-1:0] y, cb, cr, input beat_t exp);
        @(negedge clk);
        i_mode  = mode;
        i_y     = y;
        i_cb    = cb;
        i_cr    = cr;
        i_valid = 1'b1;
        #1 chk({tag, "_ready"}, o_ready, 1);
        @(posedge clk);
        #1 i_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_lat1"}, o_valid, 0);
        @(negedge clk);
        chk({tag, "_lat2"}, o_valid, 0);
        @(negedge clk);
        chk({tag, "_lat3"}, o_valid, 1);
        chk({tag, "_data"}, cur, exp);
    endtask

    initial begin
        logic [PPC*IW-1:0] ry, rcb, rcr;
        logic              acc;
        int                sent, got, loaded;
        logic              stalled;
        beat_t             held;

        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_mode  = 2'b00;
        i_y     = '0;
        i_cb    = '0;
        i_cr    = '0;
        #1;
        chk("reset_valid", o_valid, 0);
        chk("reset_data", cur, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_ready", o_ready, 1);

        directed("black",   2'b00, {PPC{8'd16}},  {PPC{8'd128}}, {PPC{8'd128}}, mk(0, 0, 0, 1'b0));
        directed("white",   2'b00, {PPC{8'd235}}, {PPC{8'd128}}, {PPC{8'd128}}, mk(255, 255, 255, 1'b0));
        directed("red",     2'b00, {PPC{8'd81}},  {PPC{8'd90}},  {PPC{8'd240}}, mk(254, 0, 0, 1'b1));
        directed("full_cr", 2'b10, {PPC{8'd255}}, {PPC{8'd128}}, {PPC{8'd255}}, mk(255, 164, 255, 1'b1));

        // Random stream with i_ready pattern 1,0,0,1 and rotating mode.
        sent    = 0;
        got     = 0;
        acc     = 1'b0;
        stalled = 1'b0;
        held    = '0;
        for (int cyc = 0; cyc < 400 && got < NBEATS; cyc++) begin
            @(negedge clk);
            if (acc) i_valid = 1'b0;
            i_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            if (!i_valid && sent < NBEATS) begin
                for (int p = 0; p < PPC; p++) begin
                    i_y[p*IW +: IW]  = IW'($urandom_range(0, MAXO));
                    i_cb[p*IW +: IW] = IW'($urandom_range(0, MAXO));
                    i_cr[p*IW +: IW] = IW'($urandom_range(0, MAXO));
                end
                i_mode  = 2'(sent);
                i_valid = 1'b1;
            end
            #1;
            if (stalled) begin
                chk("stall_valid", o_valid, 1);
                chk("stall_hold", cur, held);
            end
            chk("stream_ready", o_ready, !(exp_q.size() == 3 && !i_ready));
            if (o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    chk("stream_extra", o_valid, 0);
                end else begin
                    chk("stream_data", cur, exp_q.pop_front());
                end
                got++;
            end
            stalled = o_valid && !i_ready;
            held    = cur;
            acc     = i_valid && o_ready;
            if (acc) begin
                exp_q.push_back(model_beat(i_y, i_cb, i_cr, i_mode));
                sent++;
            end
        end
        chk("stream_count", got, NBEATS);
        chk("stream_drain", exp_q.size(), 0);

        // Fill all three stages with the output stalled, then reset asynchronously.
        @(negedge clk);
        i_valid = 1'b0;
        i_ready = 1'b0;
        loaded  = 0;
        for (int cyc = 0; cyc < 10 && loaded < 3; cyc++) begin
            @(negedge clk);
            ry  = PPC*IW'($urandom);
            rcb = PPC*IW'($urandom);
            rcr = PPC*IW'($urandom);
            i_y     = ry;
            i_cb    = rcb;
            i_cr    = rcr;
            i_mode  = 2'(cyc);
            i_valid = 1'b1;
            #1;
            if (o_ready) loaded++;
        end
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        chk("full_valid", o_valid, 1);
        chk("full_ready", o_ready, 0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", o_valid, 0);
        chk("async_rst_data", cur, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst     = 1'b0;
        i_ready = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            chk("post_rst_idle", o_valid, 0);
        end
        ry  = {8'd200, 8'd60};
        rcb = {8'd30, 8'd170};
        rcr = {8'd220, 8'd100};
        directed("post_rst", 2'b01, ry, rcb, rcr, model_beat(ry, rcb, rcr, 2'b01));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
